retire_queue: RTL and testbench
===============================

# retire_queue

In-order retire buffer that feeds the commit stage's `commit_instr_i`/`commit_ack_o` interface. Entries enter at issue in program order and take a transaction id. They are marked finished by functional-unit writebacks, which may arrive out of order. The oldest `NR_COMMIT_PORTS` entries are presented to commit every cycle, and entries retire in order when the commit stage acknowledges them. It sits between issue and commit, as the producer side of the commit handshake.

## Interface
- `NR_ENTRIES`, 8: queue depth; power of two, ≤ 2^`TRANS_ID_BITS`.
- `NR_COMMIT_PORTS`, 2: commit ports presented; ≤ `NR_ENTRIES`.
- `NR_WB_PORTS`, 4: writeback ports.
- Clock and reset (already decided): one clock `clk_i`; reset `rst_i`, asynchronous, active-high.
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous active-high reset
- `flush_i`  in  1  discard all entries
- `issue_valid_i`  in  1  new instruction offered
- `issue_instr_i`  in  `scoreboard_entry_t`  instruction; `valid`/`result`/`ex` fields ignored on entry
- `issue_ready_o`  out  1  space available
- `issue_trans_id_o`  out  `TRANS_ID_BITS`  id assigned to the offered instruction (current write pointer)
- `wb_valid_i`  in  `NR_WB_PORTS`  writeback strobe per port
- `wb_trans_id_i`  in  `NR_WB_PORTS`×`TRANS_ID_BITS`  target entry
- `wb_result_i`  in  `NR_WB_PORTS`×`XLEN`  result
- `wb_ex_i`  in  `NR_WB_PORTS`×`exception_t`  exception from the functional unit
- `commit_instr_o`  out  `NR_COMMIT_PORTS`×`scoreboard_entry_t`  oldest entries; `[0]` is the head
- `commit_ack_i`  in  `NR_COMMIT_PORTS`  retire acknowledge
- `empty_o`  out  1  no entries occupied

## Operation
- State:
  - per-entry `occupied`, `done`, and stored `scoreboard_entry_t`;
  - `rd_ptr`, `wr_ptr`, each `$clog2(NR_ENTRIES)` bits, wrapping modulo `NR_ENTRIES`;
  - `count`, `$clog2(NR_ENTRIES)+1` bits.
- Issue: when `issue_valid_i && issue_ready_o`:
  - write the entry at `wr_ptr`; `occupied`=1, `done`=0, `ex.valid`=0;
  - increment `wr_ptr`.
- `issue_ready_o` = `count < NR_ENTRIES`. It does not depend on the current-cycle ack, so there is no combinational path from commit to issue.
- Writeback: for each port with `wb_valid_i`, if the target entry is occupied and not done:
  - store `wb_result_i`;
  - set `done`;
  - if `wb_ex_i.valid`, store `wb_ex_i`.
- Writeback to an unoccupied or already-done entry is ignored. If several ports hit the same id in one cycle, the lowest port index wins.
- Commit presentation: `commit_instr_o[i]` = stored entry at `rd_ptr+i` (wrapping), with `.valid` = `occupied && done`. When the entry is not valid, the remaining fields are don't-care but stable.
- Retire: `commit_ack_i` must be a contiguous prefix (`ack[i]` implies `ack[j]` for all j<i) and only on valid entries.
  - Pop count = popcount(ack). Clear `occupied`/`done` of the popped entries; advance `rd_ptr` by the pop count.
  - A non-prefix ack or an ack on an invalid entry is a protocol error, flagged by an assertion. The RTL pops only the valid prefix.
- Count update: `count` += issue − popcount. Simultaneous issue and retire in the same cycle are allowed, including when full (full + ack: issue is still blocked that cycle).
- Flush (`flush_i`=1):
  - clear all `occupied`/`done`; `rd_ptr`=`wr_ptr`=0; `count`=0;
  - issue, writeback and ack in the same cycle are ignored.
- Reset values:
  - `issue_ready_o`=1, `issue_trans_id_o`=0, `empty_o`=1;
  - all `commit_instr_o[i]` zero with `.valid`=0;
  - pointers and `count` 0.
- Reset asserted mid-operation: the queue clears immediately (asynchronous); behaviour is identical to power-on.

## Timing
- Issue in cycle N: entry visible on `commit_instr_o` from N+1 with `.valid`=0.
- Writeback in cycle N: `.valid`=1 on the commit port from N+1 (registered, no combinational wb→commit path).
- Ack in cycle N: the next entries shift into `commit_instr_o` at N+1.
- Minimum issue-to-commit latency is 2 cycles (issue N, writeback N+1, valid N+2).
- `empty_o` and `issue_ready_o` are registered-state derived and change the cycle after the causing event.
- Retire throughput: up to `NR_COMMIT_PORTS` entries per cycle.

## Structure
- `scoreboard_entry_t`, `exception_t`, `TRANS_ID_BITS` and `XLEN` come from `ariane_pkg`/`riscv`; no new package types.
- A single module; the popcount and prefix check are local functions. No sub-module.
- Assertions (simulation only): ack prefix rule, ack only on valid entries, `count` ≤ `NR_ENTRIES`.

## Test plan
- Reset then idle: `empty_o`=1, `issue_ready_o`=1, both commit `.valid`=0.
- Issue ids 0,1,2; writeback 2 then 0:
  - port0 valid with id 0 result, port1 invalid;
  - ack[0] → port0 shows id1 (invalid);
  - writeback 1 → ids 1,2 valid; ack 2'b11 → `empty_o`=1.
- Fill all 8 entries:
  - `issue_ready_o`=0;
  - ack 2'b11 with issue offered the same cycle → no issue that cycle, `count`=6;
  - next cycle ready=1; wrap: the next id issued is 0.
- Ports 0 and 2 write back id 3 in the same cycle with results 0xA and 0xB → stored result 0xA.
- `wb_ex_i.valid` on id 1 with cause 5 → `commit_instr_o[0].ex.cause`=5 when id 1 reaches the head.
- Flush with 5 entries, concurrent writeback and issue → next cycle empty, pointers 0; a subsequent issue gets id 0.
- Assert `rst_i` asynchronously mid-traffic → outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/ariane_pkg.sv
// Minimal slice of the core-wide types shared by issue, functional units and commit.
// Field layout follows the core's scoreboard entry; only what the retire path touches matters here.
package ariane_pkg;

    localparam int XLEN          = 64;
    localparam int TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]               fu;
        logic [7:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [XLEN-1:0]          result;
        logic                     valid;
        logic                     use_imm;
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

// File: rtl/retire_queue.sv
// In-order retire buffer: entries issue in program order, finish out of order via writeback,
// and retire in order from the head as the commit stage acknowledges them.
module retire_queue
    import ariane_pkg::*;
#(
    parameter int NR_ENTRIES      = 8,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int NR_WB_PORTS     = 4
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            flush_i,
    input  logic                                            issue_valid_i,
    input  scoreboard_entry_t                               issue_instr_i,
    output logic                                            issue_ready_o,
    output logic [TRANS_ID_BITS-1:0]                        issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                          wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]       wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]                wb_result_i,
    input  exception_t [NR_WB_PORTS-1:0]                    wb_ex_i,
    output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]         commit_instr_o,
    input  logic [NR_COMMIT_PORTS-1:0]                      commit_ack_i,
    output logic                                            empty_o
);

    localparam int PW  = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
    localparam int CW  = PW + 1;
    localparam int WSW = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

    function automatic int unsigned popcount(input logic [NR_COMMIT_PORTS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    function automatic logic is_prefix(input logic [NR_COMMIT_PORTS-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 1; i < NR_COMMIT_PORTS; i++) begin
            if (v[i] && !v[i-1]) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [NR_ENTRIES-1:0]      occupied;
    logic [NR_ENTRIES-1:0]      done;
    scoreboard_entry_t          mem [NR_ENTRIES];
    logic [PW-1:0]              rd_ptr;
    logic [PW-1:0]              wr_ptr;
    logic [CW-1:0]              count;

    logic [PW-1:0]              commit_idx [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0] commit_valid;
    logic [NR_COMMIT_PORTS-1:0] pop_mask;
    logic [CW-1:0]              pop_cnt;
    logic                       issue_fire;
    scoreboard_entry_t          issue_entry;
    logic [NR_ENTRIES-1:0]      wb_hit;
    logic [WSW-1:0]             wb_sel [NR_ENTRIES];

    assign issue_ready_o    = (count < CW'(NR_ENTRIES));
    assign issue_trans_id_o = TRANS_ID_BITS'(wr_ptr);
    assign empty_o          = (count == '0);
    assign issue_fire       = issue_valid_i && issue_ready_o && !flush_i;

    always_comb begin
        issue_entry        = issue_instr_i;
        issue_entry.valid  = 1'b0;
        issue_entry.result = '0;
        issue_entry.ex     = '0;
    end

    // Head window plus the retire mask; only an unbroken run of acked valid entries pops.
    always_comb begin
        logic run;
        run            = 1'b1;
        pop_mask       = '0;
        commit_valid   = '0;
        commit_instr_o = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            commit_idx[i]           = rd_ptr + PW'(i);
            commit_valid[i]         = occupied[commit_idx[i]] && done[commit_idx[i]];
            commit_instr_o[i]       = mem[commit_idx[i]];
            commit_instr_o[i].valid = commit_valid[i];
            run                     = run && commit_ack_i[i] && commit_valid[i];
            pop_mask[i]             = run;
        end
        pop_cnt = CW'(popcount(pop_mask));
    end

    // Descending scan so the lowest-numbered port targeting an entry is the one kept.
    always_comb begin
        for (int e = 0; e < NR_ENTRIES; e++) begin
            wb_hit[e] = 1'b0;
            wb_sel[e] = '0;
            for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && (wb_trans_id_i[p] == TRANS_ID_BITS'(e))) begin
                    wb_hit[e] = 1'b1;
                    wb_sel[e] = WSW'(p);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occupied <= '0;
            done     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int e = 0; e < NR_ENTRIES; e++) begin
                mem[e] <= '0;
            end
        end else if (flush_i) begin
            occupied <= '0;
            done     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                if (wb_hit[e] && occupied[e] && !done[e]) begin
                    done[e]       <= 1'b1;
                    mem[e].result <= wb_result_i[wb_sel[e]];
                    if (wb_ex_i[wb_sel[e]].valid) begin
                        mem[e].ex <= wb_ex_i[wb_sel[e]];
                    end
                end
            end
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (pop_mask[i]) begin
                    occupied[commit_idx[i]] <= 1'b0;
                    done[commit_idx[i]]     <= 1'b0;
                end
            end
            // Issue only fires when not full, so wr_ptr never aliases a popped head slot.
            if (issue_fire) begin
                mem[wr_ptr]      <= issue_entry;
                occupied[wr_ptr] <= 1'b1;
                done[wr_ptr]     <= 1'b0;
            end
            rd_ptr <= rd_ptr + PW'(pop_cnt);
            wr_ptr <= wr_ptr + PW'(issue_fire);
            count  <= count + CW'(issue_fire) - pop_cnt;
        end
    end

`ifndef SYNTHESIS
    ack_prefix_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !flush_i |-> is_prefix(commit_ack_i));
    ack_valid_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !flush_i |-> ((commit_ack_i & ~commit_valid) == '0));
    count_bound_a: assert property (@(posedge clk_i) disable iff (rst_i)
        count <= CW'(NR_ENTRIES));
`endif

endmodule

// File: tb/tb_retire_queue.sv
// Directed bench for retire_queue: issue/writeback/retire ordering, full and wrap,
// writeback port priority, exceptions, flush and asynchronous reset.
module tb_retire_queue;
    import ariane_pkg::*;

    localparam int NE = 8;
    localparam int NC = 2;
    localparam int NW = 4;

    logic                                    clk;
    logic                                    rst;
    logic                                    flush;
    logic                                    issue_valid;
    scoreboard_entry_t                       issue_instr;
    logic                                    issue_ready;
    logic [TRANS_ID_BITS-1:0]                issue_trans_id;
    logic [NW-1:0]                           wb_valid;
    logic [NW-1:0][TRANS_ID_BITS-1:0]        wb_trans_id;
    logic [NW-1:0][XLEN-1:0]                 wb_result;
    exception_t [NW-1:0]                     wb_ex;
    scoreboard_entry_t [NC-1:0]              commit_instr;
    logic [NC-1:0]                           commit_ack;
    logic                                    empty;

    int checks = 0;
    int errors = 0;

    retire_queue #(
        .NR_ENTRIES      (NE),
        .NR_COMMIT_PORTS (NC),
        .NR_WB_PORTS     (NW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .issue_valid_i    (issue_valid),
        .issue_instr_i    (issue_instr),
        .issue_ready_o    (issue_ready),
        .issue_trans_id_o (issue_trans_id),
        .wb_valid_i       (wb_valid),
        .wb_trans_id_i    (wb_trans_id),
        .wb_result_i      (wb_result),
        .wb_ex_i          (wb_ex),
        .commit_instr_o   (commit_instr),
        .commit_ack_i     (commit_ack),
        .empty_o          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_instr = '0;
        wb_valid    = '0;
        wb_trans_id = '0;
        wb_result   = '0;
        wb_ex       = '0;
        commit_ack  = '0;
    endtask

    task automatic set_issue(input int id, input logic [63:0] pc);
        issue_valid          = 1'b1;
        issue_instr          = '0;
        issue_instr.pc       = pc;
        issue_instr.trans_id = TRANS_ID_BITS'(id);
        issue_instr.rd       = 5'(id + 1);
        issue_instr.result   = 64'hDEAD;
    endtask

    task automatic set_wb(input int port, input int id, input logic [63:0] res,
                          input logic exv, input logic [63:0] cause);
        wb_valid[port]       = 1'b1;
        wb_trans_id[port]    = TRANS_ID_BITS'(id);
        wb_result[port]      = res;
        wb_ex[port].valid    = exv;
        wb_ex[port].cause    = cause;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (3) tick();
        check("rst_ready", issue_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_tid", issue_trans_id, 0);
        check("rst_c0_valid", commit_instr[0].valid, 0);
        check("rst_c1_valid", commit_instr[1].valid, 0);
        check("rst_c0_pc", commit_instr[0].pc, 0);
        rst = 1'b0;
        tick();
        check("idle_empty", empty, 1);
        check("idle_ready", issue_ready, 1);
        check("idle_c0_valid", commit_instr[0].valid, 0);

        // Issue ids 0..2, out-of-order writeback, partial then full retire
        set_issue(0, 64'h100); tick(); clear_inputs();
        check("iss0_tid", issue_trans_id, 1);
        check("iss0_c0_valid", commit_instr[0].valid, 0);
        check("iss0_c0_pc", commit_instr[0].pc, 64'h100);
        check("iss0_c0_result", commit_instr[0].result, 0);
        set_issue(1, 64'h104); tick();
        set_issue(2, 64'h108); tick(); clear_inputs();
        check("iss2_tid", issue_trans_id, 3);
        check("iss2_empty", empty, 0);
        set_wb(0, 2, 64'h22, 1'b0, 0); tick(); clear_inputs();
        check("wb2_c0_valid", commit_instr[0].valid, 0);
        check("wb2_c1_valid", commit_instr[1].valid, 0);
        set_wb(1, 0, 64'h20, 1'b0, 0); tick(); clear_inputs();
        check("wb0_c0_valid", commit_instr[0].valid, 1);
        check("wb0_c0_result", commit_instr[0].result, 64'h20);
        check("wb0_c1_valid", commit_instr[1].valid, 0);
        commit_ack = 2'b01; tick(); clear_inputs();
        check("ack0_c0_pc", commit_instr[0].pc, 64'h104);
        check("ack0_c0_valid", commit_instr[0].valid, 0);
        check("ack0_c1_pc", commit_instr[1].pc, 64'h108);
        check("ack0_c1_valid", commit_instr[1].valid, 1);
        check("ack0_c1_result", commit_instr[1].result, 64'h22);
        set_wb(1, 1, 64'h21, 1'b1, 64'd5); tick(); clear_inputs();
        check("wb1_c0_valid", commit_instr[0].valid, 1);
        check("wb1_c0_result", commit_instr[0].result, 64'h21);
        check("wb1_c0_ex_valid", commit_instr[0].ex.valid, 1);
        check("wb1_c0_ex_cause", commit_instr[0].ex.cause, 5);
        check("wb1_c1_valid", commit_instr[1].valid, 1);
        commit_ack = 2'b11; tick(); clear_inputs();
        check("ack11_empty", empty, 1);
        check("ack11_c0_valid", commit_instr[0].valid, 0);
        check("ack11_tid", issue_trans_id, 3);

        flush = 1'b1; tick(); clear_inputs();
        check("flush0_tid", issue_trans_id, 0);
        check("flush0_empty", empty, 1);

        // Fill all eight entries
        for (int i = 0; i < NE; i++) begin
            set_issue(i, 64'h200 + 64'(4 * i)); tick(); clear_inputs();
            check("fill_tid", issue_trans_id, (i + 1) % NE);
        end
        check("full_ready", issue_ready, 0);
        check("full_empty", empty, 0);
        set_issue(0, 64'h300); tick(); clear_inputs();
        check("full_blocked_ready", issue_ready, 0);
        check("full_blocked_tid", issue_trans_id, 0);
        check("full_c0_pc", commit_instr[0].pc, 64'h200);
        set_wb(0, 0, 64'h30, 1'b0, 0);
        set_wb(1, 1, 64'h31, 1'b0, 0);
        set_wb(3, 2, 64'h32, 1'b0, 0);
        tick(); clear_inputs();
        check("full_wb_c0_valid", commit_instr[0].valid, 1);
        check("full_wb_c0_result", commit_instr[0].result, 64'h30);
        check("full_wb_c1_result", commit_instr[1].result, 64'h31);
        commit_ack = 2'b11; set_issue(0, 64'h300); tick(); clear_inputs();
        check("fullack_ready", issue_ready, 1);
        check("fullack_tid", issue_trans_id, 0);
        check("fullack_c0_pc", commit_instr[0].pc, 64'h208);
        check("fullack_c0_valid", commit_instr[0].valid, 1);
        check("fullack_c0_result", commit_instr[0].result, 64'h32);
        check("fullack_c1_pc", commit_instr[1].pc, 64'h20C);
        check("fullack_c1_valid", commit_instr[1].valid, 0);

        // Two ports hit id 3 together, then a late writeback to the finished entry
        set_wb(0, 3, 64'hA, 1'b0, 0);
        set_wb(2, 3, 64'hB, 1'b0, 0);
        tick(); clear_inputs();
        check("dualwb_c1_valid", commit_instr[1].valid, 1);
        check("dualwb_c1_result", commit_instr[1].result, 64'hA);
        set_wb(1, 3, 64'hC, 1'b0, 0); tick(); clear_inputs();
        check("donewb_c1_result", commit_instr[1].result, 64'hA);
        set_issue(0, 64'h300); tick(); clear_inputs();
        check("wrap_tid", issue_trans_id, 1);
        check("wrap_ready7", issue_ready, 1);
        set_issue(1, 64'h304); tick(); clear_inputs();
        check("wrap_ready8", issue_ready, 0);
        check("wrap_tid2", issue_trans_id, 2);

        // Flush with five entries in flight plus concurrent issue and writeback
        flush = 1'b1; tick(); clear_inputs();
        for (int i = 0; i < 5; i++) begin
            set_issue(i, 64'h400 + 64'(4 * i)); tick(); clear_inputs();
        end
        check("five_tid", issue_trans_id, 5);
        set_wb(0, 0, 64'h50, 1'b0, 0); tick(); clear_inputs();
        check("five_c0_valid", commit_instr[0].valid, 1);
        flush = 1'b1;
        set_issue(5, 64'h500);
        set_wb(0, 1, 64'h51, 1'b0, 0);
        tick(); clear_inputs();
        check("flush5_empty", empty, 1);
        check("flush5_tid", issue_trans_id, 0);
        check("flush5_ready", issue_ready, 1);
        check("flush5_c0_valid", commit_instr[0].valid, 0);
        check("flush5_c1_valid", commit_instr[1].valid, 0);
        set_issue(0, 64'h600); tick(); clear_inputs();
        check("postflush_tid", issue_trans_id, 1);
        check("postflush_c0_pc", commit_instr[0].pc, 64'h600);
        check("postflush_c0_valid", commit_instr[0].valid, 0);
        check("postflush_empty", empty, 0);

        // Asynchronous reset in the middle of a cycle
        set_issue(1, 64'h604); set_wb(2, 0, 64'h60, 1'b0, 0); tick(); clear_inputs();
        check("pre_rst_c0_valid", commit_instr[0].valid, 1);
        check("pre_rst_tid", issue_trans_id, 2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_empty", empty, 1);
        check("arst_ready", issue_ready, 1);
        check("arst_tid", issue_trans_id, 0);
        check("arst_c0_valid", commit_instr[0].valid, 0);
        check("arst_c0_pc", commit_instr[0].pc, 0);
        check("arst_c1_pc", commit_instr[1].pc, 0);
        tick();
        rst = 1'b0;
        tick();
        check("after_arst_empty", empty, 1);
        check("after_arst_c0_valid", commit_instr[0].valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
